// File: rtl/rf8_4bits.sv
// Eight 4-bit registers written through a 1-to-8 demux, with single writes
// and an auto-incrementing 8-word sequential load; q0..q7 feed ALU mux a..h.
module rf8_4bits (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       we,
  input  logic [2:0] wa,
  input  logic [3:0] d,
  input  logic       seq_start,
  input  logic       seq_valid,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [3:0] q4,
  output logic [3:0] q5,
  output logic [3:0] q6,
  output logic [3:0] q7,
  output logic [7:0] wr_hot,
  output logic       seq_busy,
  output logic       seq_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] regs [8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ptr    <= '0;
      wr_hot <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_hot <= '0;
      unique case (state)
        IDLE, DONE: begin
          // seq_start outranks a single write presented in the same cycle
          if (seq_start) begin
            state <= LOAD;
            ptr   <= '0;
          end else begin
            state <= IDLE;
            if (we) begin
              regs[wa] <= d;
              wr_hot   <= 8'b1 << wa;
            end
          end
        end
        LOAD: begin
          if (seq_start) begin
            ptr <= '0;
          end else if (seq_valid) begin
            regs[ptr] <= d;
            wr_hot    <= 8'b1 << ptr;
            if (ptr == 3'd7) begin
              state <= DONE;
              ptr   <= '0;
            end else begin
              ptr <= ptr + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign q0       = regs[0];
  assign q1       = regs[1];
  assign q2       = regs[2];
  assign q3       = regs[3];
  assign q4       = regs[4];
  assign q5       = regs[5];
  assign q6       = regs[6];
  assign q7       = regs[7];
  assign seq_busy = (state == LOAD);
  assign seq_done = (state == DONE);

endmodule

// File: doc/rf8_4bits.md
# rf8_4bits

Eight-entry, 4-bit register bank whose write side is a 1-to-8 demultiplexer: a 4-bit datum is steered to one of eight registers chosen by a 3-bit address. It supports random single writes and an auto-incrementing 8-word sequential load. Its eight outputs map one-to-one onto the eight data inputs (a..h) of the ALU's 4-bit 8-to-1 multiplexer, so the mux select reads back what this block wrote.

## Interface
Parameters: none; all widths are fixed.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  single-write enable; honoured only in IDLE or DONE.
- wa  in  3  single-write address; 0..7 selects q0..q7.
- d  in  4  write data, shared by single and sequential writes.
- seq_start  in  1  starts or restarts a sequential load.
- seq_valid  in  1  in LOAD, d is valid and is written at this edge.
- q0..q7  out  4 each  register contents; q0 feeds mux input a, …, q7 feeds h.
- wr_hot  out  8  registered one-hot of the register written at the previous edge; 0 if no write.
- seq_busy  out  1  high while in LOAD.
- seq_done  out  1  one-cycle pulse after the 8th sequential word is written.

## Operation
- The FSM has three states: IDLE, LOAD, DONE. The pointer ptr is 3 bits.
- In IDLE or DONE:
  - seq_start=1 moves to LOAD and sets ptr=0. No write occurs, and we is ignored that cycle (seq_start has priority).
  - Otherwise, we=1 writes d into register wa and sets wr_hot bit wa. The next state is IDLE.
  - With neither input asserted, DONE returns to IDLE.
- In LOAD:
  - seq_start=1 resets ptr to 0 and stays in LOAD. No write occurs, even if seq_valid=1.
  - Otherwise, seq_valid=1 writes d into register ptr and sets wr_hot bit ptr.
    - If ptr=7, go to DONE with ptr=0.
    - Otherwise, ptr increments by 1.
  - seq_valid=0 holds ptr, writes nothing, and sets wr_hot=0.
  - we and wa are ignored throughout LOAD.
- seq_busy = (state==LOAD). seq_done = (state==DONE).
- Registers not addressed by a write hold their value.
- No arithmetic is performed on data. The ptr increment is 3-bit; wrap-around is never reached because ptr=7 exits to DONE.
- Reset (reset_n=0, at any time, including mid-LOAD) immediately drives:
  - q0..q7 = 4'h0, wr_hot = 8'h00
  - seq_busy = 0, seq_done = 0
  - ptr = 0, state = IDLE
- A partially completed load is abandoned by reset. After reset is released, registers stay 0 until written.

## Timing
- Write latency is 1 cycle: d is sampled at the edge and appears on the addressed q output after that edge. wr_hot updates at the same edge.
- A sequential load takes exactly 8 seq_valid edges. Gaps, where seq_valid=0, stretch the load without limit.
- seq_busy rises the cycle after the edge that accepts seq_start.
- seq_done is high for exactly one cycle, the cycle immediately after the 8th write edge. q7 shows the new value in that same cycle.
- A single write or a seq_start presented during the DONE cycle is accepted, so back-to-back loads need no idle gap.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** drive reset_n=0 mid-cycle after arbitrary writes. Required: all q = 0, wr_hot = 0, busy = 0, done = 0 immediately, asynchronously. Release reset; q values stay 0.
- **Single writes:** we=1 with wa=0..7 and d=4'h1..4'h8. Required: one cycle after each edge, q[wa]=d and wr_hot=1<<wa; all other q unchanged. Finally q0..q7 = 1..8.
- **Sequential load with gaps:** pulse seq_start, then present d=F,E,D,C,B,A,9,8 with seq_valid deasserted for 2 cycles after the 3rd word. Required:
  - q0..q7 = F..8.
  - seq_busy high for 10 cycles.
  - seq_done is a single pulse, in the cycle after the 8th write.
  - we=1 with wa=0 during LOAD has no effect.
- **Restart and priority:** mid-load, after 4 words, assert seq_start together with seq_valid and d=5. Required: no write that cycle, ptr returns to 0, and the next valid word lands in q0. Separately, in IDLE assert we=1 with seq_start=1. Required: no write, and the block enters LOAD.
- **Reset mid-load:** assert reset_n=0 after 5 sequential words. Required: all outputs 0 and state IDLE. Then a single write with we=1, wa=3, d=7 gives q3=7 and wr_hot=8'h08.
- **Back-to-back loads:** assert seq_start during the DONE cycle. Required: seq_busy is high in the following cycle, seq_done has no second pulse until 8 more writes complete, and the second data set overwrites all registers.
